// File: rtl/div_issue_ctrl.sv
// EX-stage controller for a signed and an unsigned AXI-stream divider IP.
// Latches operands, issues both channels, holds the result until MEM accepts, drains on flush.
module div_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          QUOT_HI    = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      es_valid,
    input  logic [3:0]                div_op,
    input  logic                      flush,
    input  logic                      ms_allowin,
    input  logic [DATA_WIDTH-1:0]     src1,
    input  logic [DATA_WIDTH-1:0]     src2,
    output logic                      s_dividend_tvalid,
    output logic                      u_dividend_tvalid,
    output logic                      s_divisor_tvalid,
    output logic                      u_divisor_tvalid,
    input  logic                      s_dividend_tready,
    input  logic                      u_dividend_tready,
    input  logic                      s_divisor_tready,
    input  logic                      u_divisor_tready,
    output logic [DATA_WIDTH-1:0]     div_dividend,
    output logic [DATA_WIDTH-1:0]     div_divisor,
    input  logic                      s_dout_tvalid,
    input  logic [2*DATA_WIDTH-1:0]   s_dout_tdata,
    input  logic                      u_dout_tvalid,
    input  logic [2*DATA_WIDTH-1:0]   u_dout_tdata,
    output logic [DATA_WIDTH-1:0]     div_result,
    output logic                      div_complete,
    output logic                      div_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t                  state;
    logic [3:0]              op_r;
    logic                    use_signed;
    logic                    dividend_sent;
    logic                    divisor_sent;
    logic                    kill;

    logic                    start;
    logic                    send_dividend;
    logic                    send_divisor;
    logic                    sel_dividend_tready;
    logic                    sel_divisor_tready;
    logic                    sel_dout_tvalid;
    logic [2*DATA_WIDTH-1:0] sel_dout;
    logic                    dividend_done;
    logic                    divisor_done;
    logic [DATA_WIDTH-1:0]   dout_hi;
    logic [DATA_WIDTH-1:0]   dout_lo;
    logic [DATA_WIDTH-1:0]   quot;
    logic [DATA_WIDTH-1:0]   rem;

    assign start = es_valid & (|div_op) & ~flush;

    assign sel_dividend_tready = use_signed ? s_dividend_tready : u_dividend_tready;
    assign sel_divisor_tready  = use_signed ? s_divisor_tready  : u_divisor_tready;
    assign sel_dout_tvalid     = use_signed ? s_dout_tvalid     : u_dout_tvalid;
    assign sel_dout            = use_signed ? s_dout_tdata      : u_dout_tdata;

    assign send_dividend = (state == SEND) & ~dividend_sent;
    assign send_divisor  = (state == SEND) & ~divisor_sent;

    assign s_dividend_tvalid = send_dividend &  use_signed;
    assign u_dividend_tvalid = send_dividend & ~use_signed;
    assign s_divisor_tvalid  = send_divisor  &  use_signed;
    assign u_divisor_tvalid  = send_divisor  & ~use_signed;

    // Sent status including a beat completing this cycle.
    assign dividend_done = dividend_sent | (send_dividend & sel_dividend_tready);
    assign divisor_done  = divisor_sent  | (send_divisor  & sel_divisor_tready);

    assign dout_hi = sel_dout[2*DATA_WIDTH-1:DATA_WIDTH];
    assign dout_lo = sel_dout[DATA_WIDTH-1:0];
    assign quot    = QUOT_HI ? dout_hi : dout_lo;
    assign rem     = QUOT_HI ? dout_lo : dout_hi;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            op_r          <= '0;
            use_signed    <= 1'b0;
            dividend_sent <= 1'b0;
            divisor_sent  <= 1'b0;
            kill          <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_result    <= '0;
            div_complete  <= 1'b0;
            div_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dividend_sent <= 1'b0;
                    divisor_sent  <= 1'b0;
                    kill          <= 1'b0;
                    if (start) begin
                        div_dividend <= src1;
                        div_divisor  <= src2;
                        op_r         <= div_op;
                        use_signed   <= div_op[0] | div_op[2];
                        state        <= SEND;
                        div_busy     <= 1'b1;
                    end
                end
                SEND: begin
                    dividend_sent <= dividend_done;
                    divisor_sent  <= divisor_done;
                    // A beat landing in the flush cycle counts as sent: the IP must get its pair.
                    if (flush && !dividend_done && !divisor_done) begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end else if (dividend_done && divisor_done) begin
                        state <= (kill || flush) ? DRAIN : WAIT;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                WAIT: begin
                    if (sel_dout_tvalid) begin
                        if (flush) begin
                            state    <= IDLE;
                            div_busy <= 1'b0;
                        end else begin
                            div_result   <= (op_r[0] | op_r[1]) ? quot : rem;
                            div_complete <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (flush || ms_allowin) begin
                        state         <= IDLE;
                        div_complete  <= 1'b0;
                        div_busy      <= 1'b0;
                        dividend_sent <= 1'b0;
                        divisor_sent  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (sel_dout_tvalid) begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    div_complete <= 1'b0;
                    div_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the EX-stage divider IPs: one signed and one unsigned AXI-stream divider with separate dividend and divisor channels.
- Latches operands and sends them to the selected IP, waits for the result, then holds it until MEM accepts the instruction.
- Handles pipeline flush mid-operation by draining any in-flight IP result and discarding it.
- Sits between the EX-stage control and the ALU's divider instances; the ALU takes div_result and div_complete in place of raw IP outputs.

Parameters:
DATA_WIDTH, 32, operand/result width; IP dout is 2*DATA_WIDTH.
QUOT_HI, 1, 1 = quotient in dout[2W-1:W] and remainder in dout[W-1:0]; 0 = swapped.

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
es_valid  in  1  EX stage holds a valid instruction
div_op  in  4  one-hot {modu,mod,divu,div}; all-zero = not a divide
flush  in  1  cancel current EX instruction (exception/ertn)
ms_allowin  in  1  MEM stage can accept
src1  in  DATA_WIDTH  dividend
src2  in  DATA_WIDTH  divisor
s_dividend_tvalid / u_dividend_tvalid  out  1  signed/unsigned IP dividend valid
s_divisor_tvalid / u_divisor_tvalid  out  1  signed/unsigned IP divisor valid
s_dividend_tready / u_dividend_tready  in  1  dividend ready per IP
s_divisor_tready / u_divisor_tready  in  1  divisor ready per IP
div_dividend  out  DATA_WIDTH  latched dividend, shared by both IPs
div_divisor  out  DATA_WIDTH  latched divisor, shared by both IPs
s_dout_tvalid / u_dout_tvalid  in  1  result valid per IP
s_dout_tdata / u_dout_tdata  in  2*DATA_WIDTH  result per IP
div_result  out  DATA_WIDTH  held quotient or remainder
div_complete  out  1  result valid; EX may assert ready_go
div_busy  out  1  controller not in IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; sent flags, kill flag and operand/op registers cleared. Reset mid-operation returns to IDLE immediately; the integrator also resets the IPs.
- States: IDLE, SEND, WAIT, DONE, DRAIN.
- IDLE:
  - Start condition: es_valid & |div_op & !flush.
  - On start: latch src1, src2, div_op; select signed IP if div|mod, else unsigned; go to SEND next cycle.
  - Combinational tvalid is never asserted in IDLE.
- SEND:
  - Assert the selected IP's dividend_tvalid while its dividend_sent=0; same for divisor_tvalid / divisor_sent. Unselected IP tvalids stay 0.
  - A sent flag sets on the tvalid&tready beat.
  - When both channels have completed (including the same cycle), go to WAIT.
- WAIT: on the selected IP's dout_tvalid, capture the quotient or remainder per div_op/QUOT_HI into div_result, then go to DONE.
- DONE:
  - div_complete=1 and div_result is held stable.
  - If ms_allowin, go to IDLE, clearing the sent flags. A new divide can be accepted the following cycle.
  - Minimum latency from start to div_complete is IP latency + 2 cycles.
- Flush, by state:
  - IDLE: no start.
  - SEND with neither channel sent: go to IDLE.
  - SEND with one or both channels sent: keep sending the missing channel (the IP needs both), then go to DRAIN.
  - WAIT: go to DRAIN.
  - DONE: go to IDLE; div_complete drops next cycle.
  - DRAIN: div_complete=0; wait for the selected dout_tvalid, discard it, go to IDLE.
- div_busy=1 in every state except IDLE.
- New requests are ignored while not in IDLE.
- dout_tvalid from the unselected IP, or any dout_tvalid in IDLE, is ignored.
- Divide by zero is passed to the IP unchanged; div_result is whatever the IP returns.
- Operands are never re-sampled after the start cycle, so src changes during SEND, WAIT or DONE have no effect.

Test Plan:
- div signed, src1=100, src2=7, trdy=1, IP latency 4 -> tvalid for exactly 1 cycle; div_complete at cycle 6 after start; div_result=14.
- mod signed, src1=0xFFFFFF9C (-100), src2=7 -> div_result=0xFFFFFFFE (-2); unsigned IP tvalids stay 0 throughout.
- divu, src1=0xFFFFFFFF, src2=2; dividend tready low 3 cycles while divisor accepted at once -> divisor tvalid drops after 1 beat; dividend tvalid held 4 cycles; result 0x7FFFFFFF.
- modu, 17 % 5, ms_allowin=0 for 3 cycles in DONE -> div_complete and div_result=2 held 3 cycles; IDLE one cycle after ms_allowin=1; back-to-back divu 9/3 then returns 3.
- flush asserted in WAIT -> DRAIN; IP result arrives and is discarded; div_complete never asserted; next div 8/2 returns 4.
- flush in SEND with only divisor accepted -> dividend still sent once, then DRAIN, then IDLE. Separately, resetn low mid-WAIT -> all outputs 0 asynchronously.
